mrd_fsm_ctrl: RTL and testbench

//  Frame sequencer for the memory-reorder (mrd) block. Drives the shared 3-bit fsm code consumed by
//  the sink, read and source stages: Idle -> Sink -> Wait_to_rd -> Rd -> Wait_wr_end -> Source -> Idle.

---
 rtl/mrd_fsm_ctrl.sv | 142 ++++++++++++++
 tb/tb_mrd_fsm_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mrd_fsm_ctrl.sv
// Frame sequencer for the memory-reorder block.
// Walks Idle -> Sink -> Wait_to_rd -> Rd -> Wait_wr_end -> Source -> Idle.
// Along the way it issues start strobes, enforces watchdogs, counts frames
// and keeps sticky error flags. Every output comes straight from a register.
module mrd_fsm_ctrl #(
  parameter int WAIT_RD_CYC = 4,
  parameter int WR_LAT      = 6,
  parameter int TMO         = 4095,
  parameter int wFRM        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  input  logic            sink_end_i,
  input  logic            sink_ovt_i,
  input  logic            rd_done_i,
  input  logic            src_done_i,
  input  logic            err_clr_i,
  output logic [2:0]      fsm_o,
  output logic            rd_start_o,
  output logic            src_start_o,
  output logic            abort_o,
  output logic            busy_o,
  output logic [wFRM-1:0] frame_cnt_o,
  output logic            err_ovt_o,
  output logic            err_tmo_o,
  output logic            err_drop_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SINK = 3'd1,
    S_WRD  = 3'd2,
    S_RD   = 3'd3,
    S_WWR  = 3'd4,
    S_SRC  = 3'd5
  } state_t;

  // Terminal counter values; the counter restarts at 0 on every state change,
  // so these are the values seen in the last cycle spent in a state.
  localparam logic [11:0]     WRD_LAST = 12'(WAIT_RD_CYC - 1);
  localparam logic [11:0]     WWR_LAST = 12'(WR_LAT - 1);
  localparam logic [11:0]     TMO_LAST = 12'(TMO - 1);
  localparam logic [wFRM-1:0] FRM_ONE  = wFRM'(1);

  state_t            state_q, state_d;
  logic [11:0]       cnt_q;
  logic              rd_start_q, src_start_q, abort_q, busy_q;
  logic [wFRM-1:0]   frame_cnt_q;
  logic              err_ovt_q, err_tmo_q, err_drop_q;
  logic              set_ovt, set_tmo, set_drop, frame_done;

  // Next-state decode and error/frame event detection from the current state.
  always_comb begin
    state_d    = state_q;
    set_ovt    = 1'b0;
    set_tmo    = 1'b0;
    frame_done = 1'b0;
    set_drop   = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid_i) state_d = S_SINK;
      S_SINK: begin
        if (sink_end_i) begin
          state_d = S_WRD;
        end else if (sink_ovt_i) begin
          state_d = S_IDLE;
          set_ovt = 1'b1;
        end
      end
      S_WRD: begin
        set_drop = in_valid_i;
        if (cnt_q == WRD_LAST) state_d = S_RD;
      end
      S_RD: begin
        set_drop = in_valid_i;
        if (rd_done_i) begin
          state_d = S_WWR;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          set_tmo = 1'b1;
        end
      end
      S_WWR: begin
        set_drop = in_valid_i;
        if (cnt_q == WWR_LAST) state_d = S_SRC;
      end
      S_SRC: begin
        set_drop = in_valid_i;
        if (src_done_i) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          set_tmo = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_start_q  <= 1'b0;
      src_start_q <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_ovt_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= (state_d != state_q) ? 12'd0 : cnt_q + 12'd1;
      rd_start_q  <= (state_d == S_RD)  && (state_q != S_RD);
      src_start_q <= (state_d == S_SRC) && (state_q != S_SRC);
      abort_q     <= set_ovt | set_tmo;
      busy_q      <= (state_d != S_IDLE);
      if (frame_done) frame_cnt_q <= frame_cnt_q + FRM_ONE;
      // A new error event takes priority over a coincident clear.
      if (set_ovt)        err_ovt_q <= 1'b1;
      else if (err_clr_i) err_ovt_q <= 1'b0;
      if (set_tmo)        err_tmo_q <= 1'b1;
      else if (err_clr_i) err_tmo_q <= 1'b0;
      if (set_drop)       err_drop_q <= 1'b1;
      else if (err_clr_i) err_drop_q <= 1'b0;
    end
  end

  assign fsm_o       = state_q;
  assign rd_start_o  = rd_start_q;
  assign src_start_o = src_start_q;
  assign abort_o     = abort_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_ovt_o   = err_ovt_q;
  assign err_tmo_o   = err_tmo_q;
  assign err_drop_o  = err_drop_q;

endmodule

// File: tb/tb_mrd_fsm_ctrl.sv
// Directed bench for the mrd frame sequencer.
// Inputs change 1ns after the rising edge. Outputs are checked at the same point,
// so each tick() moves the observed outputs forward by one cycle.
module tb_mrd_fsm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, sink_end, sink_ovt, rd_done, src_done, err_clr;
  logic [2:0] fsm;
  logic       rd_start, src_start, abort, busy;
  logic [7:0] frame_cnt;
  logic       err_ovt, err_tmo, err_drop;

  int total = 0;
  int bad   = 0;

  mrd_fsm_ctrl #(
    .WAIT_RD_CYC(4),
    .WR_LAT     (6),
    .TMO        (16),
    .wFRM       (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .sink_end_i (sink_end),
    .sink_ovt_i (sink_ovt),
    .rd_done_i  (rd_done),
    .src_done_i (src_done),
    .err_clr_i  (err_clr),
    .fsm_o      (fsm),
    .rd_start_o (rd_start),
    .src_start_o(src_start),
    .abort_o    (abort),
    .busy_o     (busy),
    .frame_cnt_o(frame_cnt),
    .err_ovt_o  (err_ovt),
    .err_tmo_o  (err_tmo),
    .err_drop_o (err_drop)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sink_end = 1'b0; sink_ovt = 1'b0;
    rd_done = 1'b0; src_done = 1'b0; err_clr = 1'b0;
    tick(2);
    chk("rst_fsm", fsm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_errs", {err_ovt, err_tmo, err_drop, abort, rd_start, src_start}, 0);
    rst_n = 1'b1;
    tick();

    // Normal frame, timed so the first tick lands on t1.
    in_valid = 1'b1; tick(); in_valid = 1'b0;              // t1
    chk("nf_sink", fsm, 1);
    chk("nf_busy", busy, 1);
    tick(9);                                               // t10
    sink_end = 1'b1; tick(); sink_end = 1'b0;              // t11
    chk("nf_wrd_t11", fsm, 2);
    tick(3);                                               // t14
    chk("nf_wrd_t14", fsm, 2);
    chk("nf_rdstart_t14", rd_start, 0);
    tick();                                                // t15
    chk("nf_rd_t15", fsm, 3);
    chk("nf_rdstart_t15", rd_start, 1);
    tick();                                                // t16
    chk("nf_rdstart_t16", rd_start, 0);
    tick(4);                                               // t20
    rd_done = 1'b1; tick(); rd_done = 1'b0;                // t21
    chk("nf_wwr_t21", fsm, 4);
    tick(5);                                               // t26
    chk("nf_wwr_t26", fsm, 4);
    tick();                                                // t27
    chk("nf_src_t27", fsm, 5);
    chk("nf_srcstart_t27", src_start, 1);
    tick();                                                // t28
    chk("nf_srcstart_t28", src_start, 0);
    tick(12);                                              // t40
    src_done = 1'b1; tick(); src_done = 1'b0;              // t41
    chk("nf_idle_t41", fsm, 0);
    chk("nf_frame", frame_cnt, 1);
    chk("nf_busy_end", busy, 0);
    chk("nf_abort", abort, 0);

    // Sink overtime aborts the frame.
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick(2);
    sink_ovt = 1'b1; tick(); sink_ovt = 1'b0;
    chk("ovt_fsm", fsm, 0);
    chk("ovt_abort", abort, 1);
    chk("ovt_err", err_ovt, 1);
    tick(3);
    chk("ovt_abort_once", abort, 0);
    chk("ovt_sticky", err_ovt, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("ovt_clr", err_ovt, 0);

    // sink_end beats sink_ovt, then an Rd watchdog expiry.
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    sink_end = 1'b1; sink_ovt = 1'b1; tick(); sink_end = 1'b0; sink_ovt = 1'b0;
    chk("tie_fsm", fsm, 2);
    chk("tie_err", err_ovt, 0);
    chk("tie_abort", abort, 0);
    tick(4);
    chk("tmo_rd_first", fsm, 3);
    tick(15);
    chk("tmo_rd_16th", fsm, 3);
    chk("tmo_no_err_yet", err_tmo, 0);
    tick();
    chk("tmo_fsm", fsm, 0);
    chk("tmo_abort", abort, 1);
    chk("tmo_err", err_tmo, 1);
    chk("tmo_frame", frame_cnt, 1);
    tick();
    chk("tmo_abort_once", abort, 0);

    // rd_done arriving in the 16th Rd cycle beats the watchdog.
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    sink_end = 1'b1; tick(); sink_end = 1'b0;
    tick(4);
    tick(15);
    chk("race_rd_16th", fsm, 3);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("race_fsm", fsm, 4);
    chk("race_abort", abort, 0);

    // Overlapping in_valid during Wait_wr_end, plus clear-vs-set priority.
    in_valid = 1'b1; tick(); in_valid = 1'b0;             // WWR cycle 2
    chk("drop_err", err_drop, 1);
    chk("drop_fsm", fsm, 4);
    err_clr = 1'b1; in_valid = 1'b1; tick(); err_clr = 1'b0; in_valid = 1'b0;  // cycle 3
    chk("drop_set_wins", err_drop, 1);
    chk("drop_tmo_cleared", err_tmo, 0);
    tick(3);                                               // cycle 6
    chk("drop_wwr_last", fsm, 4);
    tick();
    chk("drop_src", fsm, 5);
    chk("drop_srcstart", src_start, 1);
    src_done = 1'b1; tick(); src_done = 1'b0;
    chk("drop_idle", fsm, 0);
    chk("drop_frame", frame_cnt, 2);

    // Done pulses that arrive while Idle are ignored.
    rd_done = 1'b1; src_done = 1'b1; sink_end = 1'b1; tick();
    rd_done = 1'b0; src_done = 1'b0; sink_end = 1'b0;
    chk("stray_fsm", fsm, 0);
    chk("stray_frame", frame_cnt, 2);

    // Reset asserted in the middle of Rd.
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    sink_end = 1'b1; tick(); sink_end = 1'b0;
    tick(4);
    chk("rrd_in_rd", fsm, 3);
    rst_n = 1'b0; tick();
    chk("rrd_fsm", fsm, 0);
    chk("rrd_outs", {busy, abort, rd_start, src_start, err_ovt, err_tmo, err_drop}, 0);
    chk("rrd_frame", frame_cnt, 0);
    rst_n = 1'b1; tick();
    chk("rrd_no_abort", abort, 0);

    // 256 short frames wrap the 8-bit counter.
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      sink_end = 1'b1; tick(); sink_end = 1'b0;
      tick(4);
      rd_done = 1'b1; tick(); rd_done = 1'b0;
      tick(6);
      src_done = 1'b1; tick(); src_done = 1'b0;
      if (i == 254) chk("wrap_255", frame_cnt, 255);
    end
    chk("wrap_0", frame_cnt, 0);
    chk("wrap_fsm", fsm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
